// File: rtl/hucio_pkg.sv
// Shared definitions for the HuC6280 timer / interrupt-controller IO pages.
package hucio_pkg;

    typedef enum logic [1:0] {
        TMR_CNT  = 2'd0,
        TMR_CTL  = 2'd1,
        IRQ_MASK = 2'd2,
        IRQ_STAT = 2'd3
    } reg_off_e;

    localparam int IRQ2_B = 0;
    localparam int IRQ1_B = 1;
    localparam int TIQ_B  = 2;

    localparam int PRESCALE_DEF = 1024;

endpackage

// File: rtl/timer_irq_ctrl_timer_core.sv
// Timer datapath: prescaler, 7-bit down counter, reload register and run flag.
module timer_core #(
    parameter int PRESCALE = 1024,
    parameter int CNT_W    = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_en,
    input  logic             load_reload,
    input  logic [CNT_W-1:0] reload_val,
    input  logic             run_wr,
    input  logic             run_val,
    output logic [CNT_W-1:0] counter,
    output logic             underflow
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0]    presc_q;
    logic [CNT_W-1:0] counter_q;
    logic [CNT_W-1:0] reload_q;
    logic             run_q;

    logic start;
    logic stop;
    logic active;
    logic wrap;

    // Writing run=1 while already running leaves counting undisturbed.
    assign start  = run_wr & run_val & ~run_q;
    assign stop   = run_wr & ~run_val;
    assign active = run_q & tick_en & ~stop;
    assign wrap   = active & (presc_q == PMAX);

    assign underflow = wrap & (counter_q == '0);
    assign counter   = counter_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q   <= '0;
            counter_q <= '0;
            reload_q  <= '0;
            run_q     <= 1'b0;
        end else begin
            if (load_reload)
                reload_q <= reload_val;
            if (run_wr)
                run_q <= run_val;
            if (start) begin
                counter_q <= reload_q;
                presc_q   <= '0;
            end else if (active) begin
                presc_q <= wrap ? '0 : presc_q + PW'(1);
                if (wrap)
                    counter_q <= (counter_q == '0) ? reload_q : counter_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/timer_irq_ctrl.sv
// Bus responder for the timer (CET_n) and interrupt controller (CECG_n) pages:
// decode, IO buffer, mask, timer-pending flag and registered read mux.
module timer_irq_ctrl
    import hucio_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEF,
    parameter int CNT_W    = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_en,
    input  logic       cet_n,
    input  logic       cecg_n,
    input  logic [1:0] addr,
    input  logic       rd,
    input  logic       wr,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    input  logic       irq1_n,
    input  logic       irq2_n,
    output logic       tiq_req,
    output logic       irq1_req,
    output logic       irq2_req
);

    logic tmr_sel, irq_sel, wr_v, rd_v;
    logic load_reload, run_wr, mask_wr, ack_wr;
    logic [CNT_W-1:0] counter;
    logic underflow;

    logic [7:0] iobuf_q, iobuf_d;
    logic [7:0] d_out_q, d_out_d;
    logic [2:0] mask_q, mask_d;
    logic       tiq_pend_q, tiq_pend_d;
    logic [7:0] rd_data;

    // Exactly one page select must be low; write beats read on a double strobe.
    assign tmr_sel = ~cet_n & cecg_n;
    assign irq_sel = cet_n & ~cecg_n;
    assign wr_v    = (tmr_sel | irq_sel) & wr;
    assign rd_v    = (tmr_sel | irq_sel) & rd & ~wr;

    assign load_reload = wr_v & tmr_sel & ~addr[0];
    assign run_wr      = wr_v & tmr_sel & addr[0];
    assign mask_wr     = wr_v & irq_sel & (addr == IRQ_MASK);
    assign ack_wr      = wr_v & irq_sel & (addr == IRQ_STAT);

    timer_core #(
        .PRESCALE(PRESCALE),
        .CNT_W   (CNT_W)
    ) u_timer_core (
        .clk        (clk),
        .reset      (reset),
        .tick_en    (tick_en),
        .load_reload(load_reload),
        .reload_val (d_in[CNT_W-1:0]),
        .run_wr     (run_wr),
        .run_val    (d_in[0]),
        .counter    (counter),
        .underflow  (underflow)
    );

    always_comb begin
        rd_data = iobuf_q;
        if (tmr_sel) begin
            rd_data = {iobuf_q[7], 7'(counter)};
        end else begin
            case (reg_off_e'(addr))
                IRQ_MASK: rd_data = {iobuf_q[7:3], mask_q};
                IRQ_STAT: rd_data = {iobuf_q[7:3], tiq_pend_q, ~irq1_n, ~irq2_n};
                default:  rd_data = iobuf_q;
            endcase
        end
    end

    // A timer underflow outranks a same-cycle acknowledge.
    always_comb begin
        iobuf_d    = iobuf_q;
        d_out_d    = d_out_q;
        mask_d     = mask_q;
        tiq_pend_d = tiq_pend_q;
        if (wr_v)
            iobuf_d = d_in;
        if (rd_v) begin
            iobuf_d = rd_data;
            d_out_d = rd_data;
        end
        if (mask_wr)
            mask_d = d_in[2:0];
        if (underflow)
            tiq_pend_d = 1'b1;
        else if (ack_wr)
            tiq_pend_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iobuf_q    <= '0;
            d_out_q    <= '0;
            mask_q     <= '0;
            tiq_pend_q <= 1'b0;
        end else begin
            iobuf_q    <= iobuf_d;
            d_out_q    <= d_out_d;
            mask_q     <= mask_d;
            tiq_pend_q <= tiq_pend_d;
        end
    end

    assign d_out    = d_out_q;
    assign tiq_req  = tiq_pend_q & ~mask_q[TIQ_B];
    assign irq1_req = ~irq1_n & ~mask_q[IRQ1_B];
    assign irq2_req = ~irq2_n & ~mask_q[IRQ2_B];

endmodule
